// File: rtl/r3_stage_sched.sv
// ---------------------------------------------------------------------------
// r3_stage_sched
//   Address/sequence controller for one in-place radix-3 DIF FFT stage over
//   an N-point frame memory. It issues one butterfly operand triplet
//   (a0, a1, a2) plus twiddle index per accepted cycle, delays the addresses
//   through a LAT-deep line so write-back addresses line up with butterfly
//   results, and pulses done once the stage has fully drained.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle stage request, only honoured in IDLE
//   cfg_span            leg spacing S, captured on an accepted start
//   cfg_tw_step         twiddle stride N/(3S), captured with cfg_span
//   iss_ready           downstream can take an issue this cycle
//   iss_valid           issue triplet valid
//   iss_a0/a1/a2        read addresses of the three legs
//   iss_tw              twiddle index k (W^k on leg 1, W^2k on leg 2)
//   wb_valid            write-back triplet valid, LAT cycles after accept
//   wb_a0/a1/a2         write-back addresses
//   busy                high in RUN and DRAIN
//   done                one-cycle completion pulse
// ---------------------------------------------------------------------------
module r3_stage_sched #(
    parameter int N      = 27,
    parameter int ADDR_W = 5,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_span,
    input  logic [ADDR_W-1:0] cfg_tw_step,
    input  logic              iss_ready,
    output logic              iss_valid,
    output logic [ADDR_W-1:0] iss_a0,
    output logic [ADDR_W-1:0] iss_a1,
    output logic [ADDR_W-1:0] iss_a2,
    output logic [ADDR_W-1:0] iss_tw,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_a0,
    output logic [ADDR_W-1:0] wb_a1,
    output logic [ADDR_W-1:0] wb_a2,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W+1:0] N_EXT = (ADDR_W+2)'(N);

    state_t state, state_next;

    logic [ADDR_W-1:0] g;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] tw_step;

    logic [ADDR_W-1:0] a0, a1, a2, tw;
    logic [ADDR_W+1:0] g_adv;
    logic              run;
    logic              accept;
    logic              last_leg;
    logic              last_fly;
    logic              pending;
    logic              start_ok;

    logic              dl_valid [LAT];
    logic [ADDR_W-1:0] dl_a0    [LAT];
    logic [ADDR_W-1:0] dl_a1    [LAT];
    logic [ADDR_W-1:0] dl_a2    [LAT];

    assign run      = (state == S_RUN);
    assign accept   = run && iss_ready;
    assign start_ok = (state == S_IDLE) && start && (cfg_span != '0);

    assign a0 = g + j;
    assign a1 = a0 + span;
    assign a2 = a1 + span;
    assign tw = j * tw_step;

    // The group base can run past N (and past 2^ADDR_W) on the final wrap,
    // so the advance is computed two bits wider before comparing to N.
    assign g_adv    = {2'b00, g} + {2'b00, span} + {1'b0, span, 1'b0};
    assign last_leg = (j == span - ONE);
    assign last_fly = last_leg && (g_adv >= N_EXT);

    // Only entries that will still be in the line after this edge matter:
    // the last stage is being presented on wb_* this cycle, so DONE can
    // follow immediately after it.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            pending = pending | dl_valid[i];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (cfg_span != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (accept && last_fly) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pending) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Captured configuration and the (g, j) butterfly counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g       <= '0;
            j       <= '0;
            span    <= '0;
            tw_step <= '0;
        end else if (start_ok) begin
            g       <= '0;
            j       <= '0;
            span    <= cfg_span;
            tw_step <= cfg_tw_step;
        end else if (accept) begin
            if (last_leg) begin
                j <= '0;
                g <= g_adv[ADDR_W-1:0];
            end else begin
                j <= j + ONE;
            end
        end
    end

    // Write-back delay line. It shifts every cycle regardless of iss_ready;
    // non-accept cycles enter as zeroed bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                dl_valid[i] <= 1'b0;
                dl_a0[i]    <= '0;
                dl_a1[i]    <= '0;
                dl_a2[i]    <= '0;
            end
        end else begin
            dl_valid[0] <= accept;
            dl_a0[0]    <= accept ? a0 : '0;
            dl_a1[0]    <= accept ? a1 : '0;
            dl_a2[0]    <= accept ? a2 : '0;
            for (int i = 1; i < LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_a0[i]    <= dl_a0[i-1];
                dl_a1[i]    <= dl_a1[i-1];
                dl_a2[i]    <= dl_a2[i-1];
            end
        end
    end

    assign iss_valid = run;
    assign iss_a0    = run ? a0 : '0;
    assign iss_a1    = run ? a1 : '0;
    assign iss_a2    = run ? a2 : '0;
    assign iss_tw    = run ? tw : '0;

    assign wb_valid  = dl_valid[LAT-1];
    assign wb_a0     = dl_a0[LAT-1];
    assign wb_a1     = dl_a1[LAT-1];
    assign wb_a2     = dl_a2[LAT-1];

    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_r3_stage_sched.sv
// ---------------------------------------------------------------------------
// tb_r3_stage_sched
//   Scoreboard bench for r3_stage_sched. Starting a stage pushes the full
//   expected triplet sequence into a queue; a monitor on the falling edge
//   pops and compares on each accepted issue, and schedules the matching
//   write-back with its due cycle.
// ---------------------------------------------------------------------------
module tb_r3_stage_sched;

    localparam int N      = 27;
    localparam int ADDR_W = 5;
    localparam int LAT    = 2;

    typedef logic [4*ADDR_W-1:0] iss_t;
    typedef struct {
        int                  due;
        logic [3*ADDR_W-1:0] addr;
    } wb_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] cfg_span;
    logic [ADDR_W-1:0] cfg_tw_step;
    logic              iss_ready;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_a0, iss_a1, iss_a2, iss_tw;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_a0, wb_a1, wb_a2;
    logic              busy;
    logic              done;

    int   checks;
    int   errors;
    int   cyc;
    int   acc_cnt;
    int   done_cnt;
    int   last_wb_cyc;
    int   ready_mode;
    bit   first_pending;
    int   first_due;

    iss_t exp_iss[$];
    wb_t  exp_wb[$];

    r3_stage_sched #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .LAT    (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_span    (cfg_span),
        .cfg_tw_step (cfg_tw_step),
        .iss_ready   (iss_ready),
        .iss_valid   (iss_valid),
        .iss_a0      (iss_a0),
        .iss_a1      (iss_a1),
        .iss_a2      (iss_a2),
        .iss_tw      (iss_tw),
        .wb_valid    (wb_valid),
        .wb_a0       (wb_a0),
        .wb_a1       (wb_a1),
        .wb_a2       (wb_a2),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver: always on, alternating, or random.
    initial begin
        iss_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       iss_ready = ~iss_ready;
                2:       iss_ready = 1'($urandom_range(0, 1));
                default: iss_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        iss_t cur;
        iss_t held;
        iss_t e;
        wb_t  w;
        bit   held_valid;
        held_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_valid = 1'b0;
            end else begin
                if (iss_valid) begin
                    cur = {iss_a0, iss_a1, iss_a2, iss_tw};
                    if (first_pending) begin
                        checkOutput("first_issue_cycle", cyc, first_due);
                        first_pending = 1'b0;
                    end
                    if (held_valid) checkOutput("stall_hold", cur, held);
                    if (iss_ready) begin
                        if (exp_iss.size() == 0) begin
                            checkOutput("iss_unexpected", exp_iss.size(), 1);
                        end else begin
                            e = exp_iss.pop_front();
                            checkOutput("iss_triplet", cur, e);
                            w.due  = cyc + LAT;
                            w.addr = e[4*ADDR_W-1:ADDR_W];
                            exp_wb.push_back(w);
                        end
                        acc_cnt++;
                        held_valid = 1'b0;
                    end else begin
                        held       = cur;
                        held_valid = 1'b1;
                    end
                end else begin
                    if (held_valid) checkOutput("stall_valid_drop", iss_valid, 1);
                    held_valid = 1'b0;
                end
                if (wb_valid) begin
                    if (exp_wb.size() == 0) begin
                        checkOutput("wb_unexpected", exp_wb.size(), 1);
                    end else begin
                        w = exp_wb.pop_front();
                        checkOutput("wb_addr", {wb_a0, wb_a1, wb_a2}, w.addr);
                        checkOutput("wb_cycle", cyc, w.due);
                    end
                    last_wb_cyc = cyc;
                end
                if (done) done_cnt++;
            end
        end
    end

    // Reference model: N/3 butterflies, groups of 3S points, S legs per group.
    task automatic startStage(input int span, input int tw, input int mode, output int st_cyc);
        ready_mode = mode;
        @(posedge clk);
        #1;
        start       = 1'b1;
        cfg_span    = ADDR_W'(span);
        cfg_tw_step = ADDR_W'(tw);
        st_cyc      = cyc;
        acc_cnt     = 0;
        if (span != 0) begin
            for (int g = 0; g < N; g += 3 * span) begin
                for (int j = 0; j < span; j++) begin
                    exp_iss.push_back({ADDR_W'(g + j), ADDR_W'(g + j + span),
                                       ADDR_W'(g + j + 2 * span), ADDR_W'((j * tw) % (1 << ADDR_W))});
                end
            end
            first_pending = 1'b1;
            first_due     = st_cyc + 1;
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        cfg_span    = ADDR_W'(1);
        cfg_tw_step = ADDR_W'(7);
    endtask

    task automatic applyStimulus(input int span, input int tw, input int mode, input bit glitch);
        int st_cyc;
        bit found;
        startStage(span, tw, mode, st_cyc);
        @(negedge clk);
        checkOutput("busy_after_start", busy, (span != 0));
        if (glitch) begin
            @(posedge clk);
            #1;
            start       = 1'b1;
            cfg_span    = ADDR_W'(3);
            cfg_tw_step = ADDR_W'(3);
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
        end
        found = done;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            found = done;
        end
        if (!found) begin
            checkOutput("done_timeout", found, 1);
            exp_iss.delete();
            exp_wb.delete();
            first_pending = 1'b0;
            return;
        end
        checkOutput("iss_remaining_at_done", exp_iss.size(), 0);
        checkOutput("wb_remaining_at_done", exp_wb.size(), 0);
        checkOutput("busy_at_done", busy, 0);
        if (span != 0) begin
            checkOutput("done_after_last_wb", cyc, last_wb_cyc + 1);
            if (mode == 0) checkOutput("done_cycle_abs", cyc, st_cyc + N / 3 + LAT + 1);
        end else begin
            checkOutput("done_cycle_span0", cyc, st_cyc + 1);
        end
        @(negedge clk);
        checkOutput("done_pulse_width", done, 0);
        checkOutput("busy_after_done", busy, 0);
    endtask

    task automatic resetMidStage();
        int  st_cyc;
        int  dc;
        bit  hit;
        startStage(9, 1, 0, st_cyc);
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(posedge clk);
            hit = (acc_cnt >= 4);
        end
        checkOutput("reach_4th_issue", hit, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_iss_valid", iss_valid, 0);
        checkOutput("abort_iss_a0", iss_a0, 0);
        checkOutput("abort_iss_tw", iss_tw, 0);
        checkOutput("abort_wb_valid", wb_valid, 0);
        checkOutput("abort_wb_a0", wb_a0, 0);
        checkOutput("abort_busy", busy, 0);
        exp_iss.delete();
        exp_wb.delete();
        first_pending = 1'b0;
        dc = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("abort_no_done", done_cnt, dc);
        checkOutput("abort_idle_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        acc_cnt       = 0;
        done_cnt      = 0;
        last_wb_cyc   = 0;
        ready_mode    = 0;
        first_pending = 1'b0;
        first_due     = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        cfg_span      = '0;
        cfg_tw_step   = '0;
        #3;
        checkOutput("reset_iss_valid", iss_valid, 0);
        checkOutput("reset_iss_addr", {iss_a0, iss_a1, iss_a2, iss_tw}, 0);
        checkOutput("reset_wb_valid", wb_valid, 0);
        checkOutput("reset_wb_addr", {wb_a0, wb_a1, wb_a2}, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] S=9 full throughput");
        applyStimulus(9, 1, 0, 1'b0);
        $display("[TB] S=3 full throughput");
        applyStimulus(3, 3, 0, 1'b0);
        $display("[TB] S=1 alternating ready");
        applyStimulus(1, 9, 1, 1'b0);
        $display("[TB] S=0 immediate done");
        applyStimulus(0, 0, 0, 1'b0);
        $display("[TB] S=9 with start pulsed mid-run");
        applyStimulus(9, 1, 0, 1'b1);
        $display("[TB] reset mid-stage");
        resetMidStage();
        applyStimulus(9, 1, 0, 1'b0);
        $display("[TB] random configs, random ready");
        for (int r = 0; r < 6; r++) begin
            int sel;
            int s;
            sel = $urandom_range(0, 2);
            s   = (sel == 0) ? 1 : (sel == 1) ? 3 : 9;
            applyStimulus(s, N / (3 * s), 2, 1'b0);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/r3_stage_sched.md
Name: r3_stage_sched

Overview:
- Address/sequence controller for one in-place radix-3 DIF FFT stage over an N-point frame memory.
- Issues one butterfly operand triplet (a0, a1, a2) per accepted cycle with its twiddle index.
- Tracks the fixed-latency butterfly pipeline (the 32-bit two-word pipeline registers in front of the butterfly) so write-back addresses emerge aligned with results.
- Signals stage completion to the top-level FFT sequencer.

Parameters:
- N, 27, frame length in points; must be a power of 3.
- ADDR_W, 5, address and twiddle-index width; 2^ADDR_W >= N.
- LAT, 2, fixed butterfly pipeline latency in cycles, from issue handshake to result valid; LAT >= 1.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run a stage; ignored unless idle
- cfg_span  in  ADDR_W  butterfly leg spacing S (N/3, N/9, ..., 1); sampled on accepted start
- cfg_tw_step  in  ADDR_W  twiddle stride, equal to N/(3S); sampled on accepted start
- iss_ready  in  1  butterfly/memory can accept an issue this cycle
- iss_valid  out  1  issue triplet valid
- iss_a0, iss_a1, iss_a2  out  ADDR_W each  read addresses of the three legs
- iss_tw  out  ADDR_W  twiddle index k; butterfly applies W^k to leg 1 and W^2k to leg 2
- wb_valid  out  1  write-back triplet valid
- wb_a0, wb_a1, wb_a2  out  ADDR_W each  write-back addresses
- busy  out  1  stage in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; counters, captured config and the LAT-deep valid/address delay line cleared. Reset asserted mid-stage aborts it with no done pulse.
- States:
  - IDLE: start with cfg_span != 0 captures config, clears g=0 and j=0, and moves to RUN. start with cfg_span == 0 moves directly to DONE with no issues.
  - RUN: iss_valid=1. Outputs a0 = g+j, a1 = a0+S, a2 = a0+2S, iss_tw = j*tw_step, with the product truncated to ADDR_W.
  - Handshake in RUN: iss_valid & iss_ready accepts the triplet. Outputs stay stable while iss_ready=0.
  - Counter advance on accept: j++. When j == S-1: j=0 and g += 3S. If that wrap carries g+3S to >= N (last butterfly), move to DRAIN.
  - DRAIN: iss_valid=0. Wait until the delay line is empty, then move to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy = 1 in RUN and DRAIN, 0 in IDLE and DONE.
- Total butterflies per stage = N/3, independent of S.
- Issue path: registered outputs; first iss_valid appears the cycle after start is accepted.
- Write-back: each accepted issue enters a LAT-stage shift register holding {valid, a0, a1, a2}. wb_valid and wb_a* come out exactly LAT cycles after the accept edge.
  - The delay line never stalls: iss_ready gates issue only.
  - Cycles with no accept insert bubbles (wb_valid=0).
- Simultaneous events: start during RUN, DRAIN or DONE is ignored and config is not recaptured. start in the same cycle done is high is ignored. A new stage may start in the cycle after done.
- Configuration legality (S a power of 3 and S*3*tw_step == N) is the caller's responsibility; behaviour for illegal values is unspecified except for S=0.

Test Plan:
- N=27, start(S=9, tw=1) at cycle 0, iss_ready=1 throughout -> issues cycles 1..9: (0,9,18,tw0), (1,10,19,tw1), ..., (8,17,26,tw8). wb_valid cycles 3..11 with the same addresses. done=1 at cycle 12 only. busy high cycles 1..11.
- start(S=3, tw=3) -> issue order (0,3,6,0), (1,4,7,3), (2,5,8,6), (9,12,15,0), (10,13,16,3), (11,14,17,6), (18,21,24,0), (19,22,25,3), (20,23,26,6). Exactly 9 wb_valid pulses.
- start(S=1, tw=9) with iss_ready low on alternate cycles -> issue (0,1,2,0), (3,4,5,0), ..., (24,25,26,0). Held stable during stalls. Each wb_valid lands exactly 2 cycles after its accept, with bubbles between. done only after the 9th wb.
- start(S=0) -> no iss_valid, no wb_valid; done pulses the cycle after start; busy stays 0.
- start pulsed again during RUN with a different cfg_span -> ignored; address sequence unchanged.
- rst_n dropped asynchronously after the 4th issue -> all outputs 0 immediately, no done pulse, no further wb_valid. After release, a new start(S=9) restarts from (0,9,18,tw0).
